hdlc_sequencer: RTL and testbench

HDLC_SEQUENCER -- requirements
Module: hdlc_sequencer

---
 rtl/hdlc_seq_pkg.sv | 36 +++
 rtl/hdlc_seq_rxslot.sv | 35 +++
 rtl/hdlc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_hdlc_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_seq_pkg.sv
// rtl/hdlc_seq_pkg.sv - Hdlc sequencer register map, bit positions, state encoding
package hdlc_seq_pkg;

    localparam logic [2:0] ADDR_TX_SC   = 3'h0;
    localparam logic [2:0] ADDR_TX_BUFF = 3'h1;
    localparam logic [2:0] ADDR_RX_SC   = 3'h2;
    localparam logic [2:0] ADDR_RX_BUFF = 3'h3;
    localparam logic [2:0] ADDR_RX_LEN  = 3'h4;

    localparam int TX_SC_ENABLE    = 1;
    localparam int TX_SC_ABORT     = 2;
    localparam int RX_SC_DROP      = 1;
    localparam int RX_SC_FRAME_ERR = 2;
    localparam int RX_SC_ABORT     = 3;
    localparam int RX_SC_OVERFLOW  = 4;
    localparam int RX_SC_FCSEN     = 5;

    localparam int MAX_FRAME = 126;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        TX_WR,
        TX_START,
        TX_WAIT,
        RX_STAT,
        RX_LEN,
        RX_RD,
        RX_DROP
    } state_t;

    function automatic logic [7:0] bit_mask(input int unsigned pos);
        return 8'(1 << pos);
    endfunction

endpackage

// File: rtl/hdlc_seq_rxslot.sv
// rtl/hdlc_seq_rxslot.sv - one-entry RX output register with valid/ready
module hdlc_seq_rxslot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_valid,
    input  logic [7:0] push_data,
    input  logic       push_last,
    input  logic       push_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       rx_err
);

    // The producer only pushes into an empty slot, so push has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_last  <= 1'b0;
            rx_err   <= 1'b0;
        end else if (push_valid) begin
            rx_valid <= 1'b1;
            rx_data  <= push_data;
            rx_last  <= push_last;
            rx_err   <= push_err & push_last;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            rx_err   <= 1'b0;
        end
    end

endmodule

// File: rtl/hdlc_sequencer.sv
// rtl/hdlc_sequencer.sv - host byte streams to Hdlc register-bus sequencer
// HDLC_SEQ_FCS_EN: adds the INIT write of FCSen and keeps Rx_SC b5 set on every write.
module hdlc_sequencer
    import hdlc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_abort,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       rx_err,
    output logic [2:0] hdlc_addr,
    output logic       hdlc_we,
    output logic       hdlc_re,
    output logic [7:0] hdlc_wdata,
    input  logic [7:0] hdlc_rdata,
    input  logic       hdlc_rx_ready,
    input  logic       hdlc_tx_done,
    output logic       rx_drop,
    output logic       tx_trunc,
    output logic [7:0] tx_frame_cnt,
    output logic [7:0] rx_frame_cnt,
    output logic       busy
);

`ifdef HDLC_SEQ_FCS_EN
    localparam logic [7:0] RX_SC_FCS   = bit_mask(RX_SC_FCSEN);
    localparam state_t     RESET_STATE = INIT;
`else
    localparam logic [7:0] RX_SC_FCS   = 8'h00;
    localparam state_t     RESET_STATE = IDLE;
`endif

    localparam logic [7:0] TX_SC_EN_VAL    = bit_mask(TX_SC_ENABLE);
    localparam logic [7:0] TX_SC_ABORT_VAL = bit_mask(TX_SC_ABORT);
    localparam logic [7:0] RX_SC_DROP_VAL  = bit_mask(RX_SC_DROP) | RX_SC_FCS;

    state_t     state;
    logic       phase;
    logic [6:0] tx_cnt;
    logic [1:0] wait_cnt;
    logic [7:0] rd_left;
    logic       rd_capture;
    logic       rx_err_cap;

    logic tx_hs;
    logic rx_done_hs;
    logic slot_free;

    assign tx_ready   = (state == TX_WR);
    assign tx_hs      = tx_valid && tx_ready;
    assign rx_done_hs = rx_valid && rx_ready && rx_last;
    assign slot_free  = !rx_valid || rx_ready;
    assign busy       = (state != IDLE) && (state != INIT);

    // Register reads return data one cycle after hdlc_re, so each read state
    // uses phase 0 for the bus cycle and phase 1 to sample hdlc_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RESET_STATE;
            phase        <= 1'b0;
            tx_cnt       <= 7'd0;
            wait_cnt     <= 2'd0;
            rd_left      <= 8'd0;
            rd_capture   <= 1'b0;
            rx_err_cap   <= 1'b0;
            hdlc_addr    <= 3'h0;
            hdlc_we      <= 1'b0;
            hdlc_re      <= 1'b0;
            hdlc_wdata   <= 8'h00;
            rx_drop      <= 1'b0;
            tx_trunc     <= 1'b0;
            tx_frame_cnt <= 8'd0;
            rx_frame_cnt <= 8'd0;
        end else begin
            hdlc_we  <= 1'b0;
            hdlc_re  <= 1'b0;
            rx_drop  <= 1'b0;
            tx_trunc <= 1'b0;
            case (state)
                INIT: begin
                    hdlc_we    <= 1'b1;
                    hdlc_addr  <= ADDR_RX_SC;
                    hdlc_wdata <= RX_SC_FCS;
                    state      <= IDLE;
                end
                IDLE: begin
                    phase <= 1'b0;
                    if (hdlc_rx_ready) begin
                        hdlc_re   <= 1'b1;
                        hdlc_addr <= ADDR_RX_SC;
                        state     <= RX_STAT;
                    end else if (tx_valid) begin
                        state <= TX_WR;
                    end
                end
                TX_WR: begin
                    if (tx_hs) begin
                        hdlc_we    <= 1'b1;
                        hdlc_addr  <= ADDR_TX_BUFF;
                        hdlc_wdata <= tx_data;
                        if (tx_last || tx_cnt == 7'(MAX_FRAME - 1)) begin
                            tx_cnt   <= 7'd0;
                            tx_trunc <= !tx_last;
                            state    <= TX_START;
                        end else begin
                            tx_cnt <= tx_cnt + 7'd1;
                        end
                    end
                end
                TX_START: begin
                    hdlc_we    <= 1'b1;
                    hdlc_addr  <= ADDR_TX_SC;
                    hdlc_wdata <= TX_SC_EN_VAL;
                    wait_cnt   <= 2'd0;
                    state      <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_abort) begin
                        hdlc_we    <= 1'b1;
                        hdlc_addr  <= ADDR_TX_SC;
                        hdlc_wdata <= TX_SC_ABORT_VAL;
                        state      <= IDLE;
                    end else if (hdlc_tx_done && wait_cnt == 2'd2) begin
                        tx_frame_cnt <= tx_frame_cnt + 8'd1;
                        state        <= IDLE;
                    end else if (wait_cnt != 2'd2) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RX_STAT: begin
                    phase <= !phase;
                    if (phase) begin
                        if (hdlc_rdata[RX_SC_FRAME_ERR] || hdlc_rdata[RX_SC_ABORT]) begin
                            hdlc_we    <= 1'b1;
                            hdlc_addr  <= ADDR_RX_SC;
                            hdlc_wdata <= RX_SC_DROP_VAL;
                            rx_drop    <= 1'b1;
                            state      <= RX_DROP;
                        end else begin
                            rx_err_cap <= hdlc_rdata[RX_SC_OVERFLOW];
                            hdlc_re    <= 1'b1;
                            hdlc_addr  <= ADDR_RX_LEN;
                            state      <= RX_LEN;
                        end
                    end
                end
                RX_LEN: begin
                    phase <= !phase;
                    if (phase) begin
                        if (hdlc_rdata == 8'd0) begin
                            hdlc_we    <= 1'b1;
                            hdlc_addr  <= ADDR_RX_SC;
                            hdlc_wdata <= RX_SC_DROP_VAL;
                            rx_drop    <= 1'b1;
                            state      <= RX_DROP;
                        end else begin
                            rd_left <= hdlc_rdata;
                            state   <= RX_RD;
                        end
                    end
                end
                RX_RD: begin
                    rd_capture <= hdlc_re;
                    // One read in flight at a time; the slot is known empty when its data lands.
                    if (rx_done_hs) begin
                        rx_frame_cnt <= rx_frame_cnt + 8'd1;
                        state        <= IDLE;
                    end else if (rd_left != 8'd0 && !hdlc_re && !rd_capture && slot_free) begin
                        hdlc_re   <= 1'b1;
                        hdlc_addr <= ADDR_RX_BUFF;
                        rd_left   <= rd_left - 8'd1;
                    end
                end
                RX_DROP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    hdlc_seq_rxslot u_rxslot (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid ((state == RX_RD) && rd_capture),
        .push_data  (hdlc_rdata),
        .push_last  (rd_left == 8'd0),
        .push_err   (rx_err_cap),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_last    (rx_last),
        .rx_err     (rx_err)
    );

endmodule

// File: tb/tb_hdlc_sequencer.sv
// tb/tb_hdlc_sequencer.sv - directed self-checking bench for hdlc_sequencer
module tb_hdlc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_abort = 1'b0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_err;
    logic [2:0] hdlc_addr;
    logic       hdlc_we;
    logic       hdlc_re;
    logic [7:0] hdlc_wdata;
    logic [7:0] hdlc_rdata = 8'h00;
    logic       hdlc_rx_ready = 1'b0;
    logic       hdlc_tx_done = 1'b1;
    logic       rx_drop;
    logic       tx_trunc;
    logic [7:0] tx_frame_cnt;
    logic [7:0] rx_frame_cnt;
    logic       busy;

`ifdef HDLC_SEQ_FCS_EN
    localparam logic [7:0] FCS = 8'h20;
`else
    localparam logic [7:0] FCS = 8'h00;
`endif

    always #5 clk = ~clk;

    hdlc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_abort      (tx_abort),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_last       (rx_last),
        .rx_err        (rx_err),
        .hdlc_addr     (hdlc_addr),
        .hdlc_we       (hdlc_we),
        .hdlc_re       (hdlc_re),
        .hdlc_wdata    (hdlc_wdata),
        .hdlc_rdata    (hdlc_rdata),
        .hdlc_rx_ready (hdlc_rx_ready),
        .hdlc_tx_done  (hdlc_tx_done),
        .rx_drop       (rx_drop),
        .tx_trunc      (tx_trunc),
        .tx_frame_cnt  (tx_frame_cnt),
        .rx_frame_cnt  (rx_frame_cnt),
        .busy          (busy)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } acc_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
    } rxb_t;

    acc_t acc_q[$];
    rxb_t rx_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_busy_cyc = 0;
    int drop_cnt = 0;
    int trunc_cnt = 0;
    int rxv_cnt = 0;
    int both_cnt = 0;
    int unstable_cnt = 0;
    int reset_acc_cnt = 0;
    int rd3_cnt = 0;
    int buff_base = 0;
    logic [7:0] rx_sc_val = 8'h00;
    logic [7:0] rx_len_val = 8'h00;
    logic [7:0] buff [8];
    logic [7:0] hold_d = 8'h00;
    logic       hold_v = 1'b0;

    // Hdlc register model plus bus/stream monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (hdlc_re) begin
            case (hdlc_addr)
                3'h2: hdlc_rdata <= rx_sc_val;
                3'h4: hdlc_rdata <= rx_len_val;
                3'h3: begin
                    hdlc_rdata <= buff[(rd3_cnt - buff_base) & 7];
                    rd3_cnt    <= rd3_cnt + 1;
                end
                default: hdlc_rdata <= 8'h00;
            endcase
        end
        if (hdlc_we || hdlc_re) acc_q.push_back('{hdlc_we, hdlc_addr, hdlc_wdata, cyc});
        if (hdlc_we && hdlc_re) both_cnt <= both_cnt + 1;
        if (!rst_n && (hdlc_we || hdlc_re)) reset_acc_cnt <= reset_acc_cnt + 1;
        if (rx_valid && rx_ready) rx_q.push_back('{rx_data, rx_last, rx_err});
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (rx_drop) drop_cnt <= drop_cnt + 1;
        if (tx_trunc) trunc_cnt <= trunc_cnt + 1;
        if (busy) last_busy_cyc <= cyc;
        if (hold_v && (!rx_valid || rx_data !== hold_d)) unstable_cnt <= unstable_cnt + 1;
        hold_v <= rx_valid && !rx_ready;
        hold_d <= rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] acc_at(input int idx);
        if (idx >= acc_q.size()) return 12'hfff;
        return {acc_q[idx].we, acc_q[idx].addr, acc_q[idx].data};
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("tx_ready_timeout", 1, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_rx_taken();
        int n = 0;
        while (!(hdlc_re && hdlc_addr == 3'h2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_stat_timeout", 1, 0);
        hdlc_rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic start_rx(input logic [7:0] sc, input logic [7:0] len);
        rx_sc_val     = sc;
        rx_len_val    = len;
        buff_base     = rd3_cnt;
        hdlc_rx_ready = 1'b1;
    endtask

    initial begin
        int mark;
        int rmark;
        int dmark;
        int vmark;
        int tmark;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {tx_ready, rx_valid, hdlc_we, hdlc_re, rx_drop, tx_trunc, busy, tx_frame_cnt, rx_frame_cnt},
              0);
        mark = acc_q.size();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef HDLC_SEQ_FCS_EN
        check("init_access_count", acc_q.size() - mark, 1);
        check("init_write", acc_at(mark), {1'b1, 3'h2, 8'h20});
`else
        check("no_init_access", acc_q.size() - mark, 0);
`endif

        // Three-byte TX frame
        mark = acc_q.size();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b1);
        wait_idle();
        check("tx3_count", acc_q.size() - mark, 4);
        check("tx3_w0", acc_at(mark), {1'b1, 3'h1, 8'hA1});
        check("tx3_w1", acc_at(mark + 1), {1'b1, 3'h1, 8'hB2});
        check("tx3_w2", acc_at(mark + 2), {1'b1, 3'h1, 8'hC3});
        check("tx3_enable", acc_at(mark + 3), {1'b1, 3'h0, 8'h02});
        check("tx3_wait_cycles", last_busy_cyc - acc_q[mark + 3].cyc, 2);
        check("tx3_frame_cnt", tx_frame_cnt, 1);

        // Four-byte RX frame, host always ready
        mark = acc_q.size();
        rmark = rx_q.size();
        buff[0] = 8'h11; buff[1] = 8'h22; buff[2] = 8'h33; buff[3] = 8'h44;
        rx_ready = 1'b1;
        start_rx(8'h00, 8'd4);
        wait_rx_taken();
        wait_idle();
        check("rx4_access_count", acc_q.size() - mark, 6);
        check("rx4_stat_read", acc_at(mark), {1'b0, 3'h2, 8'h00} | {4'h0, acc_q[mark].data});
        check("rx4_len_read", acc_at(mark + 1) >> 8, {1'b0, 3'h4});
        for (int i = 2; i < 6; i++) check("rx4_buff_read", acc_at(mark + i) >> 8, {1'b0, 3'h3});
        check("rx4_bytes", rx_q.size() - rmark, 4);
        for (int i = 0; i < 4; i++) begin
            if (rmark + i < rx_q.size()) begin
                check("rx4_data", rx_q[rmark + i].data, buff[i]);
                check("rx4_last", rx_q[rmark + i].last, (i == 3) ? 1 : 0);
            end
        end
        if (rmark + 3 < rx_q.size()) check("rx4_err", rx_q[rmark + 3].err, 0);
        check("rx4_frame_cnt", rx_frame_cnt, 1);

        // Overflow frame under back-pressure
        mark = acc_q.size();
        rmark = rx_q.size();
        buff[0] = 8'hD0; buff[1] = 8'hD1; buff[2] = 8'hD2;
        rx_ready = 1'b0;
        start_rx(8'h10, 8'd3);
        wait_rx_taken();
        repeat (20) @(negedge clk);
        check("bp_valid_held", rx_valid, 1);
        check("bp_data_held", rx_data, 8'hD0);
        check("bp_single_read", acc_q.size() - mark, 3);
        rx_ready = 1'b1;
        wait_idle();
        check("bp_bytes", rx_q.size() - rmark, 3);
        if (rmark + 2 < rx_q.size()) begin
            check("bp_last_data", rx_q[rmark + 2].data, 8'hD2);
            check("bp_last_err", {rx_q[rmark + 2].last, rx_q[rmark + 2].err}, 2'b11);
            check("bp_mid_err", rx_q[rmark + 1].err, 0);
        end
        check("bp_stable", unstable_cnt, 0);
        check("bp_frame_cnt", rx_frame_cnt, 2);

        // Frame-error drop
        mark = acc_q.size();
        dmark = drop_cnt;
        vmark = rxv_cnt;
        start_rx(8'h04, 8'd5);
        wait_rx_taken();
        wait_idle();
        check("drop_access_count", acc_q.size() - mark, 2);
        check("drop_write", acc_at(mark + 1), {1'b1, 3'h2, 8'h02 | FCS});
        check("drop_pulse", drop_cnt - dmark, 1);
        check("drop_no_valid", rxv_cnt - vmark, 0);
        check("drop_frame_cnt", rx_frame_cnt, 2);

        // Zero-length frame is dropped
        mark = acc_q.size();
        dmark = drop_cnt;
        start_rx(8'h00, 8'd0);
        wait_rx_taken();
        wait_idle();
        check("len0_access_count", acc_q.size() - mark, 3);
        check("len0_write", acc_at(mark + 2), {1'b1, 3'h2, 8'h02 | FCS});
        check("len0_pulse", drop_cnt - dmark, 1);

        // Simultaneous TX and RX requests: RX first
        mark = acc_q.size();
        rmark = rx_q.size();
        buff[0] = 8'h77;
        start_rx(8'h00, 8'd1);
        fork
            send_byte(8'h5A, 1'b1);
            wait_rx_taken();
        join
        wait_idle();
        check("sim_count", acc_q.size() - mark, 5);
        check("sim_first_stat", acc_at(mark) >> 8, {1'b0, 3'h2});
        check("sim_tx_after_rx", acc_at(mark + 3), {1'b1, 3'h1, 8'h5A});
        check("sim_enable", acc_at(mark + 4), {1'b1, 3'h0, 8'h02});
        if (rmark < rx_q.size()) check("sim_rx_byte", {rx_q[rmark].data, rx_q[rmark].last}, {8'h77, 1'b1});
        check("sim_counts", {tx_frame_cnt, rx_frame_cnt}, {8'd2, 8'd3});

        // 130 bytes without tx_last until the end: truncation at 126
        mark = acc_q.size();
        tmark = trunc_cnt;
        for (int i = 0; i < 130; i++) send_byte(8'(i), (i == 129) ? 1'b1 : 1'b0);
        wait_idle();
        check("trunc_count", acc_q.size() - mark, 132);
        check("trunc_byte126", acc_at(mark + 125), {1'b1, 3'h1, 8'd125});
        check("trunc_enable1", acc_at(mark + 126), {1'b1, 3'h0, 8'h02});
        check("trunc_second_first", acc_at(mark + 127), {1'b1, 3'h1, 8'd126});
        check("trunc_enable2", acc_at(mark + 131), {1'b1, 3'h0, 8'h02});
        check("trunc_pulse", trunc_cnt - tmark, 1);
        check("trunc_frame_cnt", tx_frame_cnt, 4);

        // Abort in TX_WAIT
        hdlc_tx_done = 1'b0;
        mark = acc_q.size();
        send_byte(8'hEE, 1'b1);
        n = 0;
        while (acc_q.size() - mark < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("abort_setup_timeout", 1, 0);
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        wait_idle();
        check("abort_count", acc_q.size() - mark, 3);
        check("abort_write", acc_at(mark + 2), {1'b1, 3'h0, 8'h04});
        check("abort_frame_cnt", tx_frame_cnt, 4);

        // Abort outside TX_WAIT is ignored
        mark = acc_q.size();
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_idle_ignored", acc_q.size() - mark, 0);
        hdlc_tx_done = 1'b1;

        // Reset in the middle of an RX frame
        rx_ready = 1'b0;
        buff[0] = 8'h99; buff[1] = 8'h98;
        start_rx(8'h00, 8'd2);
        wait_rx_taken();
        repeat (15) @(negedge clk);
        check("midrx_pending", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrx_reset_outputs",
              {tx_ready, rx_valid, hdlc_we, hdlc_re, busy, tx_frame_cnt, rx_frame_cnt}, 0);
        mark = acc_q.size();
        repeat (4) @(negedge clk);
        check("midrx_no_access", reset_acc_cnt, 0);
        check("midrx_no_log", acc_q.size() - mark, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef HDLC_SEQ_FCS_EN
        check("reinit_write", acc_at(mark), {1'b1, 3'h2, 8'h20});
`else
        check("reinit_none", acc_q.size() - mark, 0);
`endif
        check("midrx_idle", {busy, rx_valid}, 0);
        check("bus_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
